// File: rtl/mult_if.sv
// Operand/result bundle for the Mandelbrot floating-point multiplier.
// The master drives operands and start; the slave (multiplier) returns the product and status.
interface mult_if #(
  parameter int W = 27
);
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         start;
  logic [W-1:0] output_q;
  logic         done;
  logic         busy;
  logic         overflow;
  logic         underflow;

  modport master (
    output input_a, input_b, start,
    input  output_q, done, busy, overflow, underflow
  );

  modport slave (
    input  input_a, input_b, start,
    output output_q, done, busy, overflow, underflow
  );
endinterface

// File: rtl/mult.sv
// Sequential shift-add multiplier for the 27-bit {S,E,M} Mandelbrot format.
// Optional MULT_ROUND_EN selects round-half-up instead of truncation.
//
// state | meaning
// IDLE  | waiting for start; result and flags held
// MULT  | one multiplier bit per cycle, LSB first, plus one settle cycle
// NORM  | normalise, sign, exception checks; register result and pulse done
module mult #(
  parameter int SIGN_WIDTH     = 1,
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 18,
  parameter int SIZE           = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  mult_if.slave  bus
);
  localparam int W    = SIGN_WIDTH + EXPONENT_WIDTH + MANTISSA_WIDTH;
  localparam int MW   = MANTISSA_WIDTH;
  localparam int EW   = EXPONENT_WIDTH;
  localparam int PW   = 2 * MANTISSA_WIDTH;
  localparam int EXW  = EXPONENT_WIDTH + 2;
  localparam int CW   = $clog2(MANTISSA_WIDTH + 1);
  localparam int BIAS = (1 << (EXPONENT_WIDTH - 1)) - 1;
  localparam int EMAX = (1 << EXPONENT_WIDTH) - 1;

  localparam logic [SIZE-1:0] S_IDLE = SIZE'(0);
  localparam logic [SIZE-1:0] S_MULT = SIZE'(1);
  localparam logic [SIZE-1:0] S_NORM = SIZE'(2);

  logic [SIZE-1:0] r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_sign, r_zero;
  logic [EW-1:0]   r_ea, r_eb;
  logic [PW-1:0]   r_mcand, r_acc;
  logic [MW-1:0]   r_mplier;
  logic [W-1:0]    r_q;
  logic            r_done, r_ovf, r_unf;

  logic                  w_top;
  logic [MW-1:0]         w_m_trunc, w_m;
  logic signed [EXW-1:0] w_e_raw, w_e;
  logic                  w_ovf, w_unf;
  logic [W-1:0]          w_q;
  logic                  w_busy;
  logic                  w_unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_MULT;
      S_MULT:  if (r_cnt == CW'(MW)) w_next = S_NORM;
      S_NORM:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Normalisation: a product of two normalised mantissas is in [0.25, 1).
  always_comb begin
    w_top     = r_acc[PW-1];
    w_m_trunc = w_top ? r_acc[PW-1:MW] : r_acc[PW-2:MW-1];
    w_e_raw   = $signed({2'b00, r_ea} + {2'b00, r_eb} - EXW'(w_top ? BIAS : BIAS + 1));
    w_m       = w_m_trunc;
    w_e       = w_e_raw;
`ifdef MULT_ROUND_EN
    begin
      logic [MW:0] w_m_rnd;
      w_m_rnd = {1'b0, w_m_trunc} + {{MW{1'b0}}, (w_top ? r_acc[MW-1] : r_acc[MW-2])};
      if (w_m_rnd[MW]) begin
        w_m = {1'b1, {(MW-1){1'b0}}};
        w_e = w_e_raw + EXW'(1);
      end else begin
        w_m = w_m_rnd[MW-1:0];
      end
    end
    w_unused_bits = ^r_acc[MW-3:0];
`else
    w_unused_bits = ^r_acc[MW-2:0];
`endif
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_q   = {r_sign, w_e[EW-1:0], w_m};
    if (r_zero) begin
      w_q = '0;
    end else if (w_e > $signed(EXW'(EMAX))) begin
      w_q   = {r_sign, {EW{1'b1}}, {MW{1'b1}}};
      w_ovf = 1'b1;
    end else if (w_e < $signed(EXW'(1))) begin
      w_q   = '0;
      w_unf = 1'b1;
    end
    w_busy = (r_state != S_IDLE) || r_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_ea     <= '0;
      r_eb     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sign   <= bus.input_a[W-1] ^ bus.input_b[W-1];
            r_zero   <= (bus.input_a[MW-1:0] == '0) || (bus.input_b[MW-1:0] == '0);
            r_ea     <= bus.input_a[W-2:MW];
            r_eb     <= bus.input_b[W-2:MW];
            r_mcand  <= {{MW{1'b0}}, bus.input_a[MW-1:0]};
            r_mplier <= bus.input_b[MW-1:0];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
          end
        end
        S_MULT: begin
          if (r_cnt != CW'(MW)) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
          end
        end
        S_NORM: begin
          r_q    <= w_q;
          r_ovf  <= w_ovf;
          r_unf  <= w_unf;
          r_done <= 1'b1;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign bus.output_q  = r_q;
  assign bus.done      = r_done;
  assign bus.busy      = w_busy;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: directed format cases, random operands against an
// arithmetic reference model, back-to-back starts, ignored starts and reset abort.
module tb_mult;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mult_if bus ();
  mult dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic void model(input logic [26:0] a, input logic [26:0] b,
                                output logic [26:0] q, output logic ovf, output logic unf);
    longint ma, mb, p, m, rbit;
    int     e;
    logic   s;
    ma = longint'(a[17:0]);
    mb = longint'(b[17:0]);
    s  = a[26] ^ b[26];
    e  = int'(a[25:18]) + int'(b[25:18]) - 127;
    q = 27'd0; ovf = 1'b0; unf = 1'b0;
    if (ma == 0 || mb == 0) return;
    p = ma * mb;
    if (p >= (longint'(1) << 35)) begin
      m = p >> 18; rbit = (p >> 17) & 1;
    end else begin
      m = p >> 17; rbit = (p >> 16) & 1; e = e - 1;
    end
`ifdef MULT_ROUND_EN
    m = m + rbit;
    if (m == (longint'(1) << 18)) begin
      m = longint'(1) << 17; e = e + 1;
    end
`else
    rbit = 0;
`endif
    if (e > 255) begin
      q = {s, 8'hFF, 18'h3FFFF}; ovf = 1'b1;
    end else if (e < 1) begin
      unf = 1'b1;
    end else begin
      q = {s, 8'(e), 18'(m)};
    end
  endfunction

  // Drive a start now (caller is just after a rising edge); return edges until done.
  task automatic run_op(input logic [26:0] a, input logic [26:0] b, output int lat);
    bus.input_a = a;
    bus.input_b = b;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.input_a = 27'($urandom);
    bus.input_b = 27'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [26:0] a, input logic [26:0] b);
    logic [26:0] eq;
    logic        eo, eu;
    int          lat;
    model(a, b, eq, eo, eu);
    run_op(a, b, lat);
    n_checks++;
    if (lat !== 20) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected 20", name, lat);
    end
    n_checks++;
    if (bus.output_q !== eq || bus.overflow !== eo || bus.underflow !== eu) begin
      n_fail++;
      $display("FAIL %s result a=%h b=%h: got q=%h ovf=%b unf=%b expected q=%h ovf=%b unf=%b",
               name, a, b, bus.output_q, bus.overflow, bus.underflow, eq, eo, eu);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.input_a = '0; bus.input_b = '0;
    #1;
    n_checks++;
    if ({bus.output_q, bus.done, bus.busy, bus.overflow, bus.underflow} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%h done=%b busy=%b ovf=%b unf=%b expected all 0",
               bus.output_q, bus.done, bus.busy, bus.overflow, bus.underflow);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    check_op("one_times_one", 27'h2020000, 27'h2020000);
    n_checks++;
    if (bus.output_q !== 27'h2020000) begin
      n_fail++;
      $display("FAIL one_const: got %h expected 2020000", bus.output_q);
    end
    check_op("neg_1p5_times_2", 27'h6030000, 27'h2060000);
    n_checks++;
    if (bus.output_q !== 27'h6070000) begin
      n_fail++;
      $display("FAIL neg3_const: got %h expected 6070000", bus.output_q);
    end
    check_op("overflow", {1'b0, 8'hF0, 18'h20000}, {1'b0, 8'hF0, 18'h20000});
    n_checks++;
    if (bus.output_q !== 27'h3FFFFFF || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_const: got q=%h ovf=%b expected 3ffffff 1", bus.output_q, bus.overflow);
    end
    check_op("underflow", {1'b0, 8'h10, 18'h20000}, {1'b0, 8'h10, 18'h20000});
    check_op("flags_clear", 27'h2030000, 27'h2030000);
    check_op("round_case", 27'h2020001, 27'h2030000);
    check_op("round_carry", {1'b0, 8'h80, 18'h3FFFF}, {1'b0, 8'h80, 18'h3FFFF});
    check_op("zero_operand", 27'h0000000, 27'h6030000);
    check_op("zero_big_exp", {1'b1, 8'hFF, 18'h0}, {1'b0, 8'hFF, 18'h20000});
    check_op("edge_e255", {1'b0, 8'hBF, 18'h20000}, {1'b0, 8'hC0, 18'h20000});
    check_op("edge_e1", {1'b0, 8'h40, 18'h20000}, {1'b0, 8'h41, 18'h20000});
    // Let done fall so busy can be seen to drop.
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_random();
    logic [26:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = {1'($urandom), 8'($urandom), 1'b1, 17'($urandom)};
      b = {1'($urandom), 8'($urandom), 1'b1, 17'($urandom)};
      if ($urandom_range(0, 7) == 0) a[17:0] = '0;
      if (i % 2 == 0) begin
        a[25:18] = 8'($urandom_range(100, 156));
        b[25:18] = 8'($urandom_range(100, 156));
      end
      check_op("random", a, b);
    end
  endtask

  task automatic test_start_ignored();
    logic [26:0] eq;
    logic        eo, eu;
    int          dones;
    model(27'h2030000, 27'h6060000, eq, eo, eu);
    bus.input_a = 27'h2030000;
    bus.input_b = 27'h6060000;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) begin
        bus.input_a = 27'h2050000; bus.input_b = 27'h2050000; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        n_checks++;
        if (bus.output_q !== eq) begin
          n_fail++;
          $display("FAIL ignored_start_result: got %h expected %h", bus.output_q, eq);
        end
      end
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignored_start_dones: got %0d expected 1", dones);
    end
  endtask

  task automatic test_abort();
    int dones;
    bus.input_a = 27'h2030000;
    bus.input_b = 27'h2030000;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.output_q, bus.done, bus.busy, bus.overflow, bus.underflow} !== 31'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got q=%h done=%b busy=%b ovf=%b unf=%b expected all 0",
               bus.output_q, bus.done, bus.busy, bus.overflow, bus.underflow);
    end
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    n_checks++;
    if (dones !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b expected 0 0", dones, bus.busy);
    end
    check_op("after_abort", 27'h6030000, 27'h2060000);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
